line_scheduler: RTL
===================

Name: line_scheduler

Overview:
Frame-level sequencer for the multi-engine line calculator. It issues one line-start per scanline (y = 0 .. SCREEN_HEIGHT-1) and tracks line completion. It rotates the engine output through NUM_BUFS line buffers and hands each finished line to the downstream BRAM/VGA writer over a valid/ready handshake. It stalls line issue while every buffer holds an unconsumed line.

Parameters:
SCREEN_HEIGHT, 480, lines per frame
NUM_BUFS, 2, number of line buffers (legal range 2..4)
BUF_W, $clog2(NUM_BUFS), buffer index width (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
frame_start  in  1  pulse; request a new frame
abort  in  1  pulse; kill current frame
line_start  out  1  one-cycle pulse to engine block: compute line line_y
line_y  out  9  y of line being issued/computed
line_wr_buf  out  BUF_W  buffer the engines write for line_y
line_done  in  1  pulse from engine block: current line complete
line_valid  out  1  a completed buffer is available to consumer
line_ready  in  1  consumer has finished draining presented buffer
line_rd_buf  out  BUF_W  buffer index presented to consumer
line_rd_y  out  9  y of presented buffer
frame_busy  out  1  high from frame accept until frame_done/abort
frame_done  out  1  one-cycle pulse; all lines computed and consumed
stall_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; wr_ptr = rd_ptr = 0; occupancy count = 0.
- States: IDLE, ISSUE, WAIT_LINE, WAIT_BUF, FLUSH.
- IDLE:
  - frame_start=1 -> ISSUE next cycle; frame_busy=1; line_y=0; wr_ptr=rd_ptr=0; count=0.
  - frame_start in any other state is ignored.
- ISSUE: line_start=1 for exactly this one cycle, with line_wr_buf=wr_ptr; next state WAIT_LINE. Latency is frame_start sampled at edge N -> line_start high in cycle N+1.
- WAIT_LINE: on line_done:
  - Store line_y into ybuf[wr_ptr].
  - count+1; wr_ptr+1 mod NUM_BUFS.
  - If line_y==SCREEN_HEIGHT-1 -> FLUSH.
  - Else line_y+1, then go to ISSUE if post-update count<NUM_BUFS, or WAIT_BUF if count==NUM_BUFS.
  - line_done in any state other than WAIT_LINE is ignored.
- WAIT_BUF: stay until a buffer is released (count<NUM_BUFS) -> ISSUE next cycle.
- FLUSH: wait until count==0. Then pulse frame_done for one cycle, clear frame_busy, go to IDLE.
- Consumer side, active in every state:
  - line_valid = (count!=0); line_rd_buf = rd_ptr; line_rd_y = ybuf[rd_ptr].
  - line_valid&line_ready -> release: count-1, rd_ptr+1 mod NUM_BUFS.
  - line_ready while line_valid=0 has no effect.
- Simultaneous line_done and release in the same cycle: count unchanged, both pointers advance. The WAIT_LINE exit decision uses the post-update count.
- Ordering: lines reach the consumer strictly in y order; rd_ptr never passes wr_ptr.
- abort, any state: next cycle IDLE; count, pointers and line_y cleared; frame_busy=0; line_valid=0; no frame_done. abort has priority over frame_start in the same cycle.
- reset mid-frame behaves like abort and also clears stall_cycles.
- Widths: line_y is 9 bits, never exceeds SCREEN_HEIGHT-1 (no wrap inside a frame); count is BUF_W+1 bits.

Optional Feature:
LINE_SCHED_PERF_EN:
- Defined: stall_cycles counts clk cycles spent in WAIT_BUF. It is cleared when frame_start is accepted, saturates at 2^32-1, and holds its value after frame_done.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Basic frame, SCREEN_HEIGHT=4, consumer line_ready held 1, line_done 3 cycles after each line_start -> 4 line_start pulses with y=0,1,2,3 and line_rd_y=0,1,2,3 in order; single frame_done; frame_busy low after it.
- Backpressure, NUM_BUFS=2, line_ready held 0 -> after 2 line_done pulses state WAIT_BUF with no 3rd line_start. Then one line_ready -> line_start with y=2, line_wr_buf=0. With LINE_SCHED_PERF_EN, stall_cycles equals the cycles stalled.
- Simultaneous line_done and line_valid&line_ready in the same cycle at count=NUM_BUFS-1 -> count unchanged and next line issued without WAIT_BUF.
- Last line with both buffers full -> FLUSH; frame_done only after 2 releases, exactly 1 cycle after the final release is sampled.
- abort issued during WAIT_LINE at y=2 -> IDLE next cycle, line_valid=0, no frame_done. A following frame_start restarts at y=0, buffer 0.
- frame_start pulsed while busy and spurious line_done in ISSUE/WAIT_BUF -> ignored; line sequence unchanged.

Source files
------------

// File: rtl/line_scheduler_if.sv
// line_scheduler_if: frame/line handshake bundle between scheduler, engines and consumer
interface line_scheduler_if #(parameter int NUM_BUFS = 2);
  localparam int BUF_W = $clog2(NUM_BUFS);
  logic frame_start;
  logic abort;
  logic line_start;
  logic [8:0] line_y;
  logic [BUF_W-1:0] line_wr_buf;
  logic line_done;
  logic line_valid;
  logic line_ready;
  logic [BUF_W-1:0] line_rd_buf;
  logic [8:0] line_rd_y;
  logic frame_busy;
  logic frame_done;
  logic [31:0] stall_cycles;
  modport master (
    input frame_start, abort, line_done, line_ready,
    output line_start, line_y, line_wr_buf, line_valid, line_rd_buf, line_rd_y,
    frame_busy, frame_done, stall_cycles
  );
  modport slave (
    output frame_start, abort, line_done, line_ready,
    input line_start, line_y, line_wr_buf, line_valid, line_rd_buf, line_rd_y,
    frame_busy, frame_done, stall_cycles
  );
endinterface

// File: rtl/line_scheduler.sv
// line_scheduler: issues scanlines, rotates line buffers to a consumer; LINE_SCHED_PERF_EN adds the stall_cycles counter
module line_scheduler #(
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_BUFS = 2
) (
  input logic clk,
  input logic reset,
  line_scheduler_if.master bus
);
  localparam int BUF_W = $clog2(NUM_BUFS);
  localparam logic [BUF_W:0] FULL = (BUF_W+1)'(NUM_BUFS);
  localparam logic [BUF_W-1:0] PTR_MAX = BUF_W'(NUM_BUFS - 1);
  localparam logic [8:0] LAST_Y = 9'(SCREEN_HEIGHT - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LINE, WAIT_BUF, FLUSH} state_t;
  state_t state_q, state_d;
  logic [8:0] line_y_q, line_y_d;
  logic [BUF_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BUF_W:0] count_q, count_d, count_upd;
  logic [8:0] ybuf_q [NUM_BUFS];
  logic [8:0] ybuf_d [NUM_BUFS];
  logic done_acc, release_en;
  // next-state: producer side advances on accepted line_done, consumer side on release, abort wipes both
  always_comb begin
    done_acc = state_q == WAIT_LINE && bus.line_done;
    release_en = count_q != '0 && bus.line_ready;
    count_upd = count_q + (BUF_W+1)'(done_acc) - (BUF_W+1)'(release_en);
    wr_ptr_d = done_acc ? (wr_ptr_q == PTR_MAX ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = release_en ? (rd_ptr_q == PTR_MAX ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    ybuf_d = ybuf_q;
    if (done_acc) ybuf_d[wr_ptr_q] = line_y_q;
    count_d = count_upd;
    line_y_d = line_y_q;
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.frame_start) begin
        state_d = ISSUE;
        line_y_d = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d = '0;
      end
      ISSUE: state_d = WAIT_LINE;
      WAIT_LINE: if (done_acc) begin
        state_d = line_y_q == LAST_Y ? FLUSH : (count_upd < FULL ? ISSUE : WAIT_BUF);
        line_y_d = line_y_q == LAST_Y ? line_y_q : line_y_q + 9'd1;
      end
      WAIT_BUF: state_d = count_upd < FULL ? ISSUE : WAIT_BUF;
      FLUSH: state_d = count_q == '0 ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      line_y_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d = '0;
    end
  end
  // state and buffer bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      line_y_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ybuf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      line_y_q <= line_y_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ybuf_q <= ybuf_d;
    end
  end
  assign bus.line_start = state_q == ISSUE;
  assign bus.line_y = line_y_q;
  assign bus.line_wr_buf = wr_ptr_q;
  assign bus.line_valid = count_q != '0;
  assign bus.line_rd_buf = rd_ptr_q;
  assign bus.line_rd_y = ybuf_q[rd_ptr_q];
  assign bus.frame_busy = state_q != IDLE;
  assign bus.frame_done = state_q == FLUSH && count_q == '0 && !bus.abort;
`ifdef LINE_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;
  // stall counter: cleared on frame accept, saturating count of WAIT_BUF cycles
  always_comb begin
    stall_d = (state_q == IDLE && bus.frame_start && !bus.abort) ? '0 :
              (state_q == WAIT_BUF && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  end
  // stall counter register
  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = '0;
`endif
endmodule
